// File: rtl/muldiv_seq.sv
// Iterative multiply / multiply-accumulate / restoring-divide unit for the
// execute stage. It stalls the pipeline while busy and pulses done with the HI/LO result.
module muldiv_seq (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        hilo_w
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  r_mcnt;
  logic [5:0]  r_dcnt;
  logic [2:0]  r_op;
  logic [31:0] r_a, r_b, r_hi, r_lo;
  logic [31:0] r_rem, r_quo, r_dvs;
  logic [31:0] r_hi_out, r_lo_out;

  function automatic logic [31:0] f_abs(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

  function automatic logic [31:0] f_neg_if(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

  logic w_accept, w_op_is_div, w_op_sgn;
  assign w_accept    = (r_state == S_IDLE) && start && !flush;
  assign w_op_is_div = (op[2:1] == 2'b01);
  assign w_op_sgn    = ~op[0];

  // Multiply datapath: odd opcodes are the unsigned variants in both classes.
  logic        w_sgn;
  logic [63:0] w_ea, w_eb, w_prod, w_acc, w_mres;
  assign w_sgn  = ~r_op[0];
  assign w_ea   = {{32{w_sgn & r_a[31]}}, r_a};
  assign w_eb   = {{32{w_sgn & r_b[31]}}, r_b};
  assign w_prod = w_ea * w_eb;
  assign w_acc  = {r_hi, r_lo};
  assign w_mres = !r_op[2] ? w_prod : (r_op[1] ? (w_acc - w_prod) : (w_acc + w_prod));

  // Restoring divide step; r_quo starts as the dividend magnitude and shifts out.
  logic [32:0] w_shift;
  logic [33:0] w_diff;
  logic        w_ge, w_qneg, w_rneg;
  logic [31:0] w_rem_n, w_quo_n;
  assign w_shift = {r_rem, r_quo[31]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, r_dvs};
  assign w_ge    = ~w_diff[33];
  assign w_rem_n = w_ge ? w_diff[31:0] : w_shift[31:0];
  assign w_quo_n = {r_quo[30:0], w_ge};
  assign w_qneg  = w_sgn & (r_a[31] ^ r_b[31]);
  assign w_rneg  = w_sgn & r_a[31];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_mcnt   <= '0;
      r_dcnt   <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_hi_out <= '0;
      r_lo_out <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op   <= op;
          r_a    <= a;
          r_b    <= b;
          r_hi   <= hi_in;
          r_lo   <= lo_in;
          r_mcnt <= '0;
          r_dcnt <= '0;
          if (!w_op_is_div) begin
            r_state <= S_MUL;
          end else if (b == 32'd0) begin
            r_state  <= S_DONE;
            r_hi_out <= a;
            r_lo_out <= 32'hFFFF_FFFF;
          end else begin
            r_state <= S_DIV;
            r_rem   <= '0;
            r_quo   <= f_abs(a, w_op_sgn);
            r_dvs   <= f_abs(b, w_op_sgn);
          end
        end
        S_MUL: begin
          if (r_mcnt == 2'd1) begin
            r_state  <= S_DONE;
            r_hi_out <= w_mres[63:32];
            r_lo_out <= w_mres[31:0];
          end else begin
            r_mcnt <= r_mcnt + 2'd1;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_n;
          r_quo <= w_quo_n;
          if (r_dcnt == 6'd31) begin
            r_state  <= S_DONE;
            r_lo_out <= f_neg_if(w_quo_n, w_qneg);
            r_hi_out <= f_neg_if(w_rem_n, w_rneg);
          end else begin
            r_dcnt <= r_dcnt + 6'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // start may be high while reset is held, so stall is gated by resetn directly.
  assign stall  = resetn && (w_accept || (r_state == S_MUL) || (r_state == S_DIV));
  assign done   = (r_state == S_DONE) && !flush;
  assign hilo_w = done;
  assign hi_out = r_hi_out;
  assign lo_out = r_lo_out;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, arithmetic, flush and reset behaviour.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        resetn, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b, hi_in, lo_in;
  logic        stall, done, hilo_w;
  logic [31:0] hi_out, lo_out;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_seq dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .hi_in(hi_in), .lo_in(lo_in), .flush(flush), .stall(stall), .done(done),
    .hi_out(hi_out), .lo_out(lo_out), .hilo_w(hilo_w)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issues one op in cycle T and samples outputs at the negedge of cycle T+lat.
  task automatic do_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] vh, input logic [31:0] vl, input int lat,
                       output logic d, output logic s, output logic [31:0] h,
                       output logic [31:0] l, output logic early);
    next_cycle();
    start = 1'b1; flush = 1'b0; op = o; a = va; b = vb; hi_in = vh; lo_in = vl;
    next_cycle();
    start = 1'b0;
    early = 1'b0;
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      if (done || hilo_w) early = 1'b1;
      next_cycle();
    end
    @(negedge clk);
    d = done; s = stall; h = hi_out; l = lo_out;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b1; flush = 1'b0; op = 3'd0;
    a = 32'd1; b = 32'd1; hi_in = '0; lo_in = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({stall, done, hilo_w} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: stall/done/hilo_w=%b expected 000", {stall, done, hilo_w});
    end
    n_tests++;
    if ({hi_out, lo_out} !== 64'd0) begin
      n_fail++; $display("FAIL reset_data: hi/lo=%h expected 0", {hi_out, lo_out});
    end
    start = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_mult();
    next_cycle();
    start = 1'b1; op = 3'd0; a = 32'hFFFF_FFFE; b = 32'd3;
    @(negedge clk);
    n_tests++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL mult_stall_T: got %b expected 1", stall); end
    for (int k = 1; k <= 2; k++) begin
      next_cycle();
      start = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({stall, done} !== 2'b10) begin
        n_fail++; $display("FAIL mult_busy_T+%0d: stall/done=%b expected 10", k, {stall, done});
      end
    end
    next_cycle();
    @(negedge clk);
    n_tests++;
    if ({stall, done, hilo_w} !== 3'b011) begin
      n_fail++; $display("FAIL mult_done_T+3: stall/done/hilo_w=%b expected 011", {stall, done, hilo_w});
    end
    n_tests++;
    if ({hi_out, lo_out} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
      n_fail++; $display("FAIL mult_result: got %h expected ffffffff_fffffffa", {hi_out, lo_out});
    end
    next_cycle();
    @(negedge clk);
    n_tests++;
    if ({done, hi_out, lo_out} !== {1'b0, 64'hFFFF_FFFF_FFFF_FFFA}) begin
      n_fail++; $display("FAIL mult_after_done: done=%b hi/lo=%h expected 0 and held result", done, {hi_out, lo_out});
    end
  endtask

  task automatic test_mult_variants();
    logic d, s, e;
    logic [31:0] h, l;
    do_op(3'd5, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 3, d, s, h, l, e);
    n_tests++;
    if ({d, s, e, h, l} !== {3'b100, 32'd1, 32'd0}) begin
      n_fail++; $display("FAIL maddu: done/stall/early=%b hi=%h lo=%h expected 100 1 0", {d, s, e}, h, l);
    end
    do_op(3'd6, 32'd3, 32'd4, 32'd0, 32'd10, 3, d, s, h, l, e);
    n_tests++;
    if ({d, e, h, l} !== {2'b10, 64'hFFFF_FFFF_FFFF_FFFE}) begin
      n_fail++; $display("FAIL msub: done/early=%b hi=%h lo=%h expected 10 ffffffff fffffffe", {d, e}, h, l);
    end
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 3, d, s, h, l, e);
    n_tests++;
    if ({d, e, h, l} !== {2'b10, 64'hFFFF_FFFE_0000_0001}) begin
      n_fail++; $display("FAIL multu_max: done/early=%b hi=%h lo=%h expected 10 fffffffe 00000001", {d, e}, h, l);
    end
    do_op(3'd7, 32'd2, 32'd3, 32'd0, 32'd5, 3, d, s, h, l, e);
    n_tests++;
    if ({d, e, h, l} !== {2'b10, 64'hFFFF_FFFF_FFFF_FFFF}) begin
      n_fail++; $display("FAIL msubu_wrap: done/early=%b hi=%h lo=%h expected 10 ffffffff ffffffff", {d, e}, h, l);
    end
    do_op(3'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 3, d, s, h, l, e);
    n_tests++;
    if ({d, e, h, l} !== {2'b10, 64'hFFFF_FFFF_FFFF_FFFF}) begin
      n_fail++; $display("FAIL madd_neg: done/early=%b hi=%h lo=%h expected 10 ffffffff ffffffff", {d, e}, h, l);
    end
  endtask

  task automatic test_div();
    logic d, s, e;
    logic [31:0] h, l;
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 33, d, s, h, l, e);
    n_tests++;
    if ({d, s, e, h, l} !== {3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      n_fail++; $display("FAIL div_neg7_2: done/stall/early=%b hi=%h lo=%h expected 100 ffffffff fffffffd", {d, s, e}, h, l);
    end
    do_op(3'd3, 32'd7, 32'd0, 32'd0, 32'd0, 1, d, s, h, l, e);
    n_tests++;
    if ({d, s, h, l} !== {2'b10, 32'd7, 32'hFFFF_FFFF}) begin
      n_fail++; $display("FAIL divu_by0: done/stall=%b hi=%h lo=%h expected 10 7 ffffffff", {d, s}, h, l);
    end
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 33, d, s, h, l, e);
    n_tests++;
    if ({d, e, h, l} !== {2'b10, 32'd0, 32'h8000_0000}) begin
      n_fail++; $display("FAIL div_minint: done/early=%b hi=%h lo=%h expected 10 0 80000000", {d, e}, h, l);
    end
    do_op(3'd3, 32'd100, 32'd7, 32'd0, 32'd0, 33, d, s, h, l, e);
    n_tests++;
    if ({d, e, h, l} !== {2'b10, 32'd2, 32'd14}) begin
      n_fail++; $display("FAIL divu_100_7: done/early=%b hi=%h lo=%h expected 10 2 e", {d, e}, h, l);
    end
    do_op(3'd2, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'd0, 33, d, s, h, l, e);
    n_tests++;
    if ({d, e, h, l} !== {2'b10, 32'd1, 32'hFFFF_FFFD}) begin
      n_fail++; $display("FAIL div_7_neg2: done/early=%b hi=%h lo=%h expected 10 1 fffffffd", {d, e}, h, l);
    end
    do_op(3'd3, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 33, d, s, h, l, e);
    n_tests++;
    if ({d, e, h, l} !== {2'b10, 32'd1, 32'h7FFF_FFFC}) begin
      n_fail++; $display("FAIL divu_big: done/early=%b hi=%h lo=%h expected 10 1 7ffffffc", {d, e}, h, l);
    end
  endtask

  task automatic test_flush();
    logic seen;
    next_cycle();
    start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd3;
    next_cycle();
    start = 1'b0;
    repeat (9) next_cycle();
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_div_stall: got %b expected 0", stall); end
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || hilo_w || stall) seen = 1'b1;
      next_cycle();
    end
    n_tests++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_div_quiet: activity=%b expected 0", seen); end

    start = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd2; b = 32'd2;
    @(negedge clk);
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_accept_stall: got %b expected 0", stall); end
    next_cycle();
    start = 1'b0; flush = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done || stall) seen = 1'b1;
      next_cycle();
    end
    n_tests++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_accept_quiet: activity=%b expected 0", seen); end

    start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd2;
    next_cycle();
    start = 1'b0;
    next_cycle();
    next_cycle();
    flush = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({done, hilo_w, stall} !== 3'b000) begin
      n_fail++; $display("FAIL flush_done: done/hilo_w/stall=%b expected 000", {done, hilo_w, stall});
    end
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({done, stall} !== 2'b00) begin
      n_fail++; $display("FAIL flush_done_after: done/stall=%b expected 00", {done, stall});
    end
  endtask

  task automatic test_start_ignored();
    next_cycle();
    start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3; hi_in = '0; lo_in = '0;
    next_cycle();
    op = 3'd1; a = 32'd100; b = 32'd100;
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_tests++;
    if ({done, hi_out, lo_out} !== {1'b1, 32'd0, 32'd6}) begin
      n_fail++; $display("FAIL start_ignored: done=%b hi/lo=%h expected 1 and 6", done, {hi_out, lo_out});
    end
    next_cycle();
    start = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({done, stall} !== 2'b00) begin
      n_fail++; $display("FAIL start_ignored_idle: done/stall=%b expected 00", {done, stall});
    end
  endtask

  task automatic test_reset_mid_div();
    logic d, s, e;
    logic [31:0] h, l;
    next_cycle();
    start = 1'b1; op = 3'd3; a = 32'd12345; b = 32'd10;
    next_cycle();
    start = 1'b0;
    repeat (5) next_cycle();
    #2;
    resetn = 1'b0;
    #1;
    n_tests++;
    if ({stall, done, hilo_w, hi_out, lo_out} !== 67'd0) begin
      n_fail++; $display("FAIL reset_mid_div: stall/done/hilo_w=%b hi/lo=%h expected all 0",
                         {stall, done, hilo_w}, {hi_out, lo_out});
    end
    #2;
    resetn = 1'b1;
    do_op(3'd1, 32'd5, 32'd6, 32'd0, 32'd0, 3, d, s, h, l, e);
    n_tests++;
    if ({d, e, h, l} !== {2'b10, 32'd0, 32'd30}) begin
      n_fail++; $display("FAIL reset_then_multu: done/early=%b hi=%h lo=%h expected 10 0 1e", {d, e}, h, l);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_mult_variants();
    test_div();
    test_flush();
    test_start_ignored();
    test_reset_mid_div();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1: execute stage holds a MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU instruction.
REQ-004 SHALL have port op, input, 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
REQ-005 SHALL have ports a and b, input, 32 each: already-forwarded rs and rt values.
REQ-006 SHALL have ports hi_in and lo_in, input, 32 each: already-forwarded HI and LO, used as the accumulator for MADD/MSUB.
REQ-007 SHALL have port flush, input, 1: exception or ERET kill of the execute-stage instruction.
REQ-008 SHALL have port stall, output, 1: freeze F/D/E and insert a bubble into M.
REQ-009 SHALL have port done, output, 1: one-cycle result-valid pulse.
REQ-010 SHALL have ports hi_out and lo_out, output, 32 each: result, valid only while done=1.
REQ-011 SHALL have port hilo_w, output, 1: write HI and LO together; equals done.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-013 SHALL accept an operation in cycle T when the FSM is in IDLE, start=1 and flush=0.
- On accept, SHALL latch op, a, b, hi_in and lo_in.
- start in MUL, DIV or DONE SHALL be ignored.
REQ-014 stall SHALL be (IDLE & start & !flush) | MUL | DIV, and SHALL be 0 in DONE so the pipeline advances in the done cycle.
REQ-015 Multiply class (op 0,1,4-7): IDLE->MUL on accept; a 2-bit counter moves MUL->DONE so that done=1 in cycle T+3.
REQ-016 Signed ops (0,4,6) SHALL sign-extend a and b to 64 bits; unsigned ops SHALL zero-extend. Product width SHALL be 64.
REQ-017 MADD/MADDU SHALL produce {hi_in,lo_in}+product; MSUB/MSUBU SHALL produce {hi_in,lo_in}-product. Both SHALL use 64-bit wrap-around arithmetic with no overflow trap.
REQ-018 Divide class (op 2,3): IDLE->DIV on accept; radix-2 restoring divide on magnitudes, one quotient bit per cycle, 6-bit counter 0..31; done=1 in cycle T+33.
REQ-019 Divide result: lo_out=quotient, hi_out=remainder.
- Signed: quotient negative iff sign(a)!=sign(b); remainder takes sign(a).
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo_out=0x80000000, hi_out=0.
REQ-021 b=0 for DIV or DIVU SHALL go IDLE->DONE directly (done in T+1) with lo_out=0xFFFFFFFF and hi_out=a; there SHALL be no exception.
REQ-022 DONE SHALL last exactly one cycle and then return to IDLE; done, hilo_w and stall SHALL NOT be asserted together.
REQ-023 flush=1 in any state SHALL force IDLE at the next edge with no done/hilo_w. flush in the accept cycle SHALL prevent acceptance. flush in DONE SHALL suppress done and hilo_w in that cycle.
REQ-024 hi_out and lo_out SHALL hold their last value outside DONE; consumers SHALL qualify them with done.

Reset
REQ-025 resetn=0 SHALL asynchronously force IDLE, counters 0, latched operands 0, and stall=0, done=0, hilo_w=0, hi_out=0, lo_out=0.
REQ-026 Reset asserted mid-MUL or mid-DIV SHALL abandon the operation with no done pulse; after release the block SHALL be in IDLE, ready in the first cycle.

Verification
REQ-027 MULT a=0xFFFFFFFE (-2), b=3 accepted in cycle T -> stall 1 through T+2; in T+3 done=1, hi_out=0xFFFFFFFF, lo_out=0xFFFFFFFA.
REQ-028 MADDU hi_in=0, lo_in=0xFFFFFFFF, a=1, b=1 -> done at T+3, hi_out=1, lo_out=0.
REQ-029 DIV a=0xFFFFFFF9 (-7), b=2 -> done at T+33, lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF; DIVU a=7, b=0 -> done at T+1, lo_out=0xFFFFFFFF, hi_out=7.
REQ-030 DIV accepted, flush=1 at T+10 -> IDLE at T+11, no done for 40 cycles, stall 0 from T+11.
REQ-031 resetn pulsed low mid-DIV (between clock edges) -> outputs 0 immediately; a MULTU 5x6 started in the first cycle after release -> lo_out=30, hi_out=0, 3 cycles later.
